// File: rtl/dpram_stream_pkg.sv
// dpram_stream_pkg: state encoding and skid sizing shared by dpram_stream_reader and stream_skid2
package dpram_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CW = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/stream_skid2.sv
// stream_skid2: two-entry in-order buffer; the head register drives out_data/out_valid
module stream_skid2 import dpram_stream_pkg::*; #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic [SKID_CW-1:0]   count
);
    logic [DATAWIDTH-1:0] tail;
    logic [SKID_CW-1:0] slot;
    assign slot = count - SKID_CW'(pop);
    assign out_valid = count != '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            count <= slot + SKID_CW'(push);
            if (pop) out_data <= tail;
            if (push && slot == '0) out_data <= push_data;
            if (push && slot == SKID_CW'(1)) tail <= push_data;
        end
    end
endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: streams a burst of RAM words through a 2-entry skid buffer.
// DPRAM_STREAM_READER_CLEAR_EN: each word read is zeroed on the following port cycle.
module dpram_stream_reader import dpram_stream_pkg::*; #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic [ADDRWIDTH:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] ram_address,
    output logic                 ram_wren,
    output logic [DATAWIDTH-1:0] ram_data,
    input  logic [DATAWIDTH-1:0] ram_q,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
`ifdef DPRAM_STREAM_READER_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif
    state_t state, state_n;
    logic [ADDRWIDTH-1:0] base_q;
    logic [ADDRWIDTH:0] to_issue, to_send;
    logic [SKID_CW-1:0] count;
    logic primed, inflight, wr_phase, accept, issue, pop, last;
    assign busy = state != IDLE;
    assign pop = out_valid && out_ready;
    assign last = pop && to_send == (ADDRWIDTH+1)'(1);
    assign accept = state == IDLE && start && !done;
    assign ram_wren = wr_phase;
    assign ram_data = '0;
    // occupancy is taken net of the word leaving this cycle, so a full-rate stream needs only two slots
    always_comb begin
        issue = state == RUN && primed && !wr_phase &&
                ({1'b0, count} - (SKID_CW+1)'(pop) + (SKID_CW+1)'(inflight)) < (SKID_CW+1)'(SKID_DEPTH);
        state_n = state;
        if (state == IDLE && accept && length != '0) state_n = RUN;
        if (state == RUN && issue && to_issue == (ADDRWIDTH+1)'(1)) state_n = DRAIN;
        if (state == DRAIN && last) state_n = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // ram_address is loaded one cycle into RUN; a read counts as issued on the edge the RAM samples it
    always_ff @(posedge clock) begin
        if (reset) begin
            done <= 1'b0;
            ram_address <= '0;
            base_q <= '0;
            to_issue <= '0;
            to_send <= '0;
            primed <= 1'b0;
            inflight <= 1'b0;
            wr_phase <= 1'b0;
        end else begin
            done <= (accept && length == '0) || (state == DRAIN && last);
            inflight <= issue;
            wr_phase <= CLEAR && issue;
            if (accept) begin
                base_q <= base_addr;
                to_issue <= length;
                to_send <= length;
                primed <= 1'b0;
            end
            if (state == RUN && !primed) begin
                ram_address <= base_q;
                primed <= 1'b1;
            end
            if (issue) to_issue <= to_issue - 1'b1;
            if ((issue && !CLEAR) || wr_phase) ram_address <= ram_address + 1'b1;
            if (pop) to_send <= to_send - 1'b1;
        end
    end
    stream_skid2 #(.DATAWIDTH(DATAWIDTH)) u_skid (
        .clock(clock),
        .reset(reset),
        .push(inflight),
        .push_data(ram_q),
        .pop(pop),
        .out_data(out_data),
        .out_valid(out_valid),
        .count(count)
    );
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: table-driven and randomised bursts against a RAM-snapshot reference model
module tb_dpram_stream_reader;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0, init_req = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] length = '0;
    logic busy, done, ram_wren, out_valid;
    logic [7:0] ram_address, ram_data, ram_q, out_data;
    logic [7:0] mem [256];
    int checks = 0, errors = 0;
`ifdef DPRAM_STREAM_READER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int STEP = CLR ? 2 : 1;
    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int pct;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;
    vec_t vecs [7];
    dpram_stream_reader #(.ADDRWIDTH(8), .DATAWIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (init_req) for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
        else if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic init_mem();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
    endtask
    task automatic burst(input logic [7:0] b, input logic [8:0] n, input int pct, input bit use_exp,
                         input logic [7:0] exp_first, input logic [7:0] exp_last, input bit restart_on_done);
        logic [7:0] m [256];
        logic [7:0] expq [$], got [$], prev_data, addr0;
        int xc [$];
        int t = 0, first_v = -1, done_t = -1, dones = 0, busy_n0 = 0, unstable = 0, bad = 0, ram_bad = 0;
        bit stalled = 1'b0;
        for (int i = 0; i < 256; i++) m[i] = mem[i];
        for (int i = 0; i < int'(n); i++) begin
            expq.push_back(m[8'(int'(b) + i)]);
            if (CLR) m[8'(int'(b) + i)] = 8'h00;
        end
        addr0 = ram_address;
        base_addr = b;
        length = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, n != 0);
        while (t < 20000 && (done_t < 0 || t < done_t + 4)) begin
            if (t == 1) check("addr_after_n1", ram_address, n != 0 ? b : addr0);
            if (stalled && (!out_valid || out_data !== prev_data)) unstable++;
            if (out_valid && first_v < 0) first_v = t;
            if (busy && n == 0) busy_n0++;
            if (restart_on_done && done_t >= 0 && t == done_t + 1) begin
                start = 1'b0;
                check("start_on_done_ignored", busy, 0);
            end
            if (done) begin
                dones++;
                if (done_t < 0) begin
                    done_t = t;
                    check("busy_low_at_done", busy, 0);
                    if (restart_on_done) begin
                        start = 1'b1;
                        base_addr = 8'hAA;
                        length = 9'd3;
                    end
                end
            end
            out_ready = ($urandom_range(99) < pct);
            stalled = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                xc.push_back(t);
            end
            tick();
            t++;
        end
        check("done_seen", done_t >= 0, 1);
        check("word_count", got.size(), n);
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] !== expq[i]) bad++;
        check("word_order", bad, 0);
        check("done_pulses", dones, 1);
        check("stall_stable", unstable, 0);
        if (n == 0) begin
            check("len0_done_time", done_t, 0);
            check("len0_no_valid", first_v, -1);
            check("len0_no_busy", busy_n0, 0);
        end else begin
            check("first_valid_latency", first_v, 3);
            if (got.size() > 0) check("done_after_last", done_t, xc[$] + 1);
            if (pct >= 100 && got.size() == int'(n)) check("throughput", xc[$] - xc[0], (int'(n) - 1) * STEP);
            if (use_exp && got.size() > 0) begin
                check("first_word", got[0], exp_first);
                check("last_word", got[$], exp_last);
            end
        end
        for (int i = 0; i < 256; i++) if (mem[i] !== m[i]) ram_bad++;
        check("ram_after", ram_bad, 0);
    endtask
    initial begin
        int seen, dcount;
        vecs[0] = '{8'h10, 9'd4, 100, 8'h11, 8'h14};
        vecs[1] = '{8'hFE, 9'd4, 100, 8'hFF, 8'h02};
        vecs[2] = '{8'h00, 9'd8, 50, 8'h01, 8'h08};
        vecs[3] = '{8'h33, 9'd0, 100, 8'h00, 8'h00};
        vecs[4] = '{8'h80, 9'd256, 100, 8'h81, 8'h80};
        vecs[5] = '{8'h05, 9'd300, 70, 8'h06, CLR ? 8'h00 : 8'h31};
        vecs[6] = '{8'hF0, 9'd1, 100, 8'hF1, 8'hF1};
        init_mem();
        tick();
        check("reset_outputs", {busy, done, out_valid, ram_wren, out_data, ram_address, ram_data}, 0);
        reset = 1'b0;
        tick();
        for (int v = 0; v < 7; v++) begin
            init_mem();
            burst(vecs[v].base, vecs[v].len, vecs[v].pct, 1'b1, vecs[v].first, vecs[v].last, 1'b0);
        end
        init_mem();
        burst(8'h60, 9'd2, 100, 1'b1, 8'h61, 8'h62, 1'b1);
        burst(8'h70, 9'd3, 100, 1'b1, 8'h71, 8'h73, 1'b0);
        init_mem();
        base_addr = 8'h40;
        length = 9'd6;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            if (out_valid) seen++;
            if (seen < 3) tick();
        end
        check("abort_reached_word3", seen, 3);
        check("abort_word3", out_data, 8'h43);
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_outputs", {busy, done, out_valid, ram_wren, out_data, ram_address, ram_data}, 0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy || out_valid) dcount++;
            tick();
        end
        check("abort_quiet", dcount, 0);
        burst(8'h10, 9'd4, 100, 1'b1, 8'h11, 8'h14, 1'b0);
        init_mem();
        for (int r = 0; r < 6; r++)
            burst(8'($urandom), 9'($urandom_range(0, 511)), $urandom_range(30, 100), 1'b0, 8'h00, 8'h00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
